// File: rtl/sr_flag_arbiter_if.sv
// Command/status bundle between requesters and the SR flag arbiter.
// master drives commands; slave is the arbiter side.
interface sr_flag_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 8
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*NFLAGS-1:0] req_set;
  logic [NREQ*NFLAGS-1:0] req_clr;
  logic [NREQ-1:0]        req_lock;
  logic [NREQ-1:0]        req_ready;
  logic                   err_clr;
  logic [NFLAGS-1:0]      flags;
  logic                   err;
  logic [NFLAGS-1:0]      err_bits;
  logic [OW-1:0]          owner;

  modport master (
    output req_valid, req_set, req_clr, req_lock, err_clr,
    input  req_ready, flags, err, err_bits, owner
  );

  modport slave (
    input  req_valid, req_set, req_clr, req_lock, err_clr,
    output req_ready, flags, err, err_bits, owner
  );
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter with grant locking in front of a shared set/reset flag register.
// Set+clear on the same bit holds the bit and records a sticky conflict.

module sr_flag_cell (
  input  logic clk,
  input  logic reset,
  input  logic xfer,
  input  logic set,
  input  logic clr,
  input  logic err_clr,
  output logic hit,
  output logic q,
  output logic conflict_q
);
  assign hit = xfer & set & clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      q          <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      if (xfer && set && !clr)      q <= 1'b1;
      else if (xfer && clr && !set) q <= 1'b0;
      // a fresh conflict wins over a coincident clear
      if (err_clr)  conflict_q <= hit;
      else if (hit) conflict_q <= 1'b1;
    end
  end
endmodule

module sr_flag_arbiter #(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 8
) (
  input logic clk,
  input logic reset,
  sr_flag_arbiter_if.slave bus
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ARB, LOCKED} state_t;

  state_t            state, state_nxt;
  logic [OW-1:0]     rr_ptr, owner_q, gidx;
  logic [NREQ-1:0]   ready;
  logic              xfer, found, err_q;
  logic [NFLAGS-1:0] set_sel, clr_sel, hit_v, flags_q, err_bits_q;
  int                idx;

  function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  // grant select: owner only while locked, else first valid at/after rr_ptr
  always_comb begin
    ready = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    if (!reset) begin
      if (state == LOCKED) begin
        if (bus.req_valid[owner_q]) begin
          ready[owner_q] = 1'b1;
          gidx           = owner_q;
        end
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          idx = int'(rr_ptr) + k;
          if (idx >= NREQ) idx = idx - NREQ;
          if (!found && bus.req_valid[idx]) begin
            found      = 1'b1;
            ready[idx] = 1'b1;
            gidx       = OW'(idx);
          end
        end
      end
    end
  end

  assign xfer    = |ready;
  assign set_sel = xfer ? bus.req_set[gidx*NFLAGS +: NFLAGS] : '0;
  assign clr_sel = xfer ? bus.req_clr[gidx*NFLAGS +: NFLAGS] : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (xfer && bus.req_lock[gidx])     state_nxt = LOCKED;
      LOCKED:  if (xfer && !bus.req_lock[owner_q]) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARB;
      rr_ptr  <= '0;
      owner_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        owner_q <= gidx;
        // a continuing lock leaves the round-robin pointer untouched
        if (state == ARB || !bus.req_lock[owner_q]) rr_ptr <= wrap_inc(gidx);
      end
      if (bus.err_clr) err_q <= |hit_v;
      else if (|hit_v) err_q <= 1'b1;
    end
  end

  sr_flag_cell u_cell [NFLAGS-1:0] (
    .clk        (clk),
    .reset      (reset),
    .xfer       (xfer),
    .set        (set_sel),
    .clr        (clr_sel),
    .err_clr    (bus.err_clr),
    .hit        (hit_v),
    .q          (flags_q),
    .conflict_q (err_bits_q)
  );

  assign bus.req_ready = ready;
  assign bus.flags     = flags_q;
  assign bus.err       = err_q;
  assign bus.err_bits  = err_bits_q;
  assign bus.owner     = owner_q;
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed checks of grant order, locking, SR flag updates, conflict error and reset.
module tb_sr_flag_arbiter;
  localparam int NREQ = 4, NFLAGS = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  sr_flag_arbiter_if #(.NREQ(NREQ), .NFLAGS(NFLAGS)) bus ();

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAGS(NFLAGS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_all();
    bus.req_valid = '0;
    bus.req_set   = '0;
    bus.req_clr   = '0;
    bus.req_lock  = '0;
    bus.err_clr   = 1'b0;
  endtask

  task automatic mask(input int i, input logic [7:0] s, input logic [7:0] c);
    bus.req_set[i*NFLAGS +: NFLAGS] = s;
    bus.req_clr[i*NFLAGS +: NFLAGS] = c;
  endtask

  // advance one edge, then settle outputs
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_all();
    reset = 1'b1;
    bus.req_valid = 4'b1111;
    tick();
    tick();
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_flags", 32'(bus.flags), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_errbits", 32'(bus.err_bits), 32'h0);
    chk("rst_owner", 32'(bus.owner), 32'h0);

    // round-robin sweep
    reset = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rr_ready%0d", c), 32'(bus.req_ready), 32'(1 << c));
      tick();
      chk($sformatf("rr_owner%0d", c), 32'(bus.owner), 32'(c));
    end
    chk("rr_wrap", 32'(bus.req_ready), 32'h1);

    // set then clear; req3 mask not granted, must be ignored
    clr_all();
    bus.req_valid = 4'b0001;
    mask(0, 8'h0F, 8'h00);
    mask(3, 8'hFF, 8'h00);
    #1;
    chk("sc_ready0", 32'(bus.req_ready), 32'h1);
    chk("sc_flags_pre", 32'(bus.flags), 32'h0);
    tick();
    chk("sc_flags_0F", 32'(bus.flags), 32'h0F);
    clr_all();
    bus.req_valid = 4'b0010;
    mask(1, 8'h00, 8'h03);
    tick();
    chk("sc_flags_0C", 32'(bus.flags), 32'h0C);

    // conflict on bit0 from req2
    clr_all();
    bus.req_valid = 4'b0100;
    mask(2, 8'h81, 8'h01);
    tick();
    chk("cf_flags", 32'(bus.flags), 32'h8C);
    chk("cf_err", 32'(bus.err), 32'h1);
    chk("cf_errbits", 32'(bus.err_bits), 32'h01);
    clr_all();
    bus.err_clr = 1'b1;
    tick();
    chk("ec_err", 32'(bus.err), 32'h0);
    chk("ec_errbits", 32'(bus.err_bits), 32'h0);
    chk("ec_flags", 32'(bus.flags), 32'h8C);

    // bring rr_ptr to 1, then lock on req1
    clr_all();
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b1111;
    bus.req_lock  = 4'b0010;
    for (int g = 0; g < 3; g++) begin
      #1;
      chk($sformatf("lk_ready%0d", g), 32'(bus.req_ready), 32'h2);
      tick();
      chk($sformatf("lk_owner%0d", g), 32'(bus.owner), 32'h1);
      if (g == 1) begin
        bus.req_valid = 4'b1101;
        #1;
        chk("lk_owner_idle", 32'(bus.req_ready), 32'h0);
        tick();
        bus.req_valid = 4'b1111;
      end
    end
    bus.req_lock = 4'b0000;
    #1;
    chk("lk_release_ready", 32'(bus.req_ready), 32'h2);
    tick();
    chk("lk_resume_req2", 32'(bus.req_ready), 32'h4);

    // lock req2 with all flags set, then conflict to raise err
    mask(2, 8'hFF, 8'h00);
    bus.req_lock = 4'b0100;
    tick();
    mask(2, 8'h01, 8'h01);
    #1;
    chk("lk2_ready", 32'(bus.req_ready), 32'h4);
    tick();
    chk("lk2_flags", 32'(bus.flags), 32'hFF);
    chk("lk2_err", 32'(bus.err), 32'h1);
    mask(2, 8'h00, 8'hFF);
    reset = 1'b1;
    #1;
    chk("rl_ready", 32'(bus.req_ready), 32'h0);
    tick();
    chk("rl_flags", 32'(bus.flags), 32'h0);
    chk("rl_err", 32'(bus.err), 32'h0);
    chk("rl_owner", 32'(bus.owner), 32'h0);
    reset = 1'b0;
    clr_all();
    bus.req_valid = 4'b1111;
    #1;
    chk("rl_arb_req0", 32'(bus.req_ready), 32'h1);

    // conflict on bit0, then err_clr alongside a new conflict on bit4
    mask(0, 8'h01, 8'h01);
    tick();
    chk("ecn_pre_errbits", 32'(bus.err_bits), 32'h01);
    clr_all();
    bus.req_valid = 4'b0010;
    mask(1, 8'h10, 8'h10);
    bus.err_clr = 1'b1;
    tick();
    chk("ecn_err", 32'(bus.err), 32'h1);
    chk("ecn_errbits", 32'(bus.err_bits), 32'h10);
    chk("ecn_flags", 32'(bus.flags), 32'h0);
    clr_all();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
